// File: rtl/ram_sync_ctl.sv
// ram_sync_ctl
//   Synchronous RAM controller for the PDP-11 core memory path. Replaces a
//   zero-latency rd/wr/byte_op RAM with a request/done handshake, adds
//   programmable wait states, byte-lane writes and error reporting for odd
//   word addresses, non-existent memory and rd/wr conflicts.
//
//   Ports
//     clk       in   clock, rising edge
//     reset     in   synchronous, active-high
//     addr      in   byte address; word index = addr[ADDR_W-1:1]
//     data_in   in   write data, lane-aligned
//     rd, wr    in   request strobes, sampled only while idle
//     byte_op   in   1 = byte access, lane selected by addr[0]
//     data_out  out  read data (full word), holds until the next good read
//     busy      out  request in progress
//     done      out  one-cycle completion strobe
//     err       out  completion had an error (meaningful with done)
//     err_code  out  00 none, 01 odd word addr, 10 NXM, 11 rd&wr conflict
//
//   Timing: a request accepted at edge N performs its memory access on edge
//   N+WAIT_STATES (the edge entering ACK) and done is high in the cycle after
//   edge N+1+WAIT_STATES, so back-to-back accesses run every WAIT_STATES+2
//   cycles.
module ram_sync_ctl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_WORDS   = 16384,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  input  logic              byte_op,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int IW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            r_state;
  logic [3:0]        r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_byte;
  logic              r_rd;
  logic              r_wr;
  logic              r_err;
  logic [1:0]        r_code;

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic              w_go;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din;
  logic              w_byte;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-2:0] w_idx;
  logic              w_nxm;
  logic [1:0]        w_code;
  logic              w_ok;
  logic [IW-1:0]     w_midx;

  // With zero wait states the access happens on the accept edge itself, so
  // the operands come straight from the ports; otherwise from the latches.
  assign w_addr = (r_state == S_IDLE) ? addr    : r_addr;
  assign w_din  = (r_state == S_IDLE) ? data_in : r_din;
  assign w_byte = (r_state == S_IDLE) ? byte_op : r_byte;
  assign w_rd   = (r_state == S_IDLE) ? rd      : r_rd;
  assign w_wr   = (r_state == S_IDLE) ? wr      : r_wr;

  // Edge entering ACK. Reset on that edge suppresses the access entirely.
  assign w_go = !reset &&
                (((r_state == S_IDLE) && (rd || wr) && (WAIT_STATES == 0)) ||
                 ((r_state == S_WAIT) && (r_count == 4'd1)));

  assign w_idx  = w_addr[ADDR_W-1:1];
  assign w_nxm  = (32'(w_idx) >= MEM_WORDS);
  assign w_midx = w_idx[IW-1:0];

  // First matching error wins.
  always_comb begin
    w_code = 2'b00;
    if (w_rd && w_wr)
      w_code = 2'b11;
    else if (!w_byte && w_addr[0])
      w_code = 2'b01;
    else if (w_nxm)
      w_code = 2'b10;
  end

  assign w_ok = (w_code == 2'b00);

  // Memory array: never reset, written lane by lane so byte writes leave the
  // other lane untouched.
  always_ff @(posedge clk) begin
    if (w_go && w_ok && w_wr) begin
      if (!w_byte || !w_addr[0])
        r_mem[w_midx][7:0] <= w_din[7:0];
      if (!w_byte || w_addr[0])
        r_mem[w_midx][15:8] <= w_din[15:8];
    end
  end

  // Request latches: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && (rd || wr)) begin
      r_addr <= addr;
      r_din  <= data_in;
      r_byte <= byte_op;
      r_rd   <= rd;
      r_wr   <= wr;
    end
    if (w_go) begin
      r_err  <= !w_ok;
      r_code <= w_code;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      data_out <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (rd || wr) begin
            busy <= 1'b1;
            if (WAIT_STATES == 0) begin
              r_state <= S_ACK;
            end else begin
              r_state <= S_WAIT;
              r_count <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1)
            r_state <= S_ACK;
        end
        S_ACK: begin
          r_state  <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          err      <= r_err;
          err_code <= r_code;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_go && w_ok && w_rd)
        data_out <= r_mem[w_midx];
    end
  end

endmodule

// File: tb/tb_ram_sync_ctl.sv
// Testbench for ram_sync_ctl. Three instances with WAIT_STATES 1, 3 and 0.
// Directed requests push their expected completion into a queue; a monitor
// pops and compares whenever any instance raises done.
module tb_ram_sync_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v;
  logic [2:0]  rd_v, wr_v, by_v;
  logic [2:0]  busy_v, done_v, err_v;
  logic [15:0] addr_v [3];
  logic [15:0] din_v  [3];
  logic [15:0] dout_v [3];
  logic [1:0]  code_v [3];

  int lat [3] = '{2, 4, 1};

  ram_sync_ctl #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(16384), .WAIT_STATES(1)) u_a (
    .clk(clk), .reset(rst_v[0]), .addr(addr_v[0]), .data_in(din_v[0]),
    .rd(rd_v[0]), .wr(wr_v[0]), .byte_op(by_v[0]), .data_out(dout_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .err_code(code_v[0]));

  ram_sync_ctl #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(16384), .WAIT_STATES(3)) u_b (
    .clk(clk), .reset(rst_v[1]), .addr(addr_v[1]), .data_in(din_v[1]),
    .rd(rd_v[1]), .wr(wr_v[1]), .byte_op(by_v[1]), .data_out(dout_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .err_code(code_v[1]));

  ram_sync_ctl #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(16384), .WAIT_STATES(0)) u_c (
    .clk(clk), .reset(rst_v[2]), .addr(addr_v[2]), .data_in(din_v[2]),
    .rd(rd_v[2]), .wr(wr_v[2]), .byte_op(by_v[2]), .data_out(dout_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]), .err_code(code_v[2]));

  typedef struct {
    int          sel;
    int          id;
    logic        err;
    logic [1:0]  code;
    logic        chk;
    logic [15:0] dat;
  } exp_t;

  exp_t  q [$];
  string names [$];
  exp_t  m_e;
  int    n_vec  = 0;
  int    n_miss = 0;

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_v[k] === 1'b1) begin
        n_vec++;
        if (q.size() == 0) begin
          n_miss++;
          $display("FAIL dut%0d spurious done: got done=1 err=%b code=%b, want no done",
                   k, err_v[k], code_v[k]);
        end else begin
          m_e = q.pop_front();
          if (m_e.sel != k || err_v[k] !== m_e.err || code_v[k] !== m_e.code ||
              (m_e.chk && dout_v[k] !== m_e.dat)) begin
            n_miss++;
            $display("FAIL %s: got dut%0d err=%b code=%b data=%o, want dut%0d err=%b code=%b data=%o",
                     names[m_e.id], k, err_v[k], code_v[k], dout_v[k],
                     m_e.sel, m_e.err, m_e.code, m_e.dat);
          end
        end
      end
    end
  end

  // Issue one request to instance s. rst_at<0: normal access, latency checked.
  // rst_at>0: reset is asserted across the rst_at-th edge after acceptance and
  // no completion is expected.
  task automatic drive(input int s, input string nm, input logic r, input logic w,
                       input logic b, input logic [15:0] ad, input logic [15:0] din,
                       input logic e_err, input logic [1:0] e_code, input logic chk,
                       input logic [15:0] e_dat, input logic pulse, input int rst_at);
    exp_t e;
    int   cyc;
    @(negedge clk);
    rd_v[s] = r; wr_v[s] = w; by_v[s] = b; addr_v[s] = ad; din_v[s] = din;
    if (rst_at < 0) begin
      names.push_back(nm);
      e.sel = s; e.id = names.size() - 1; e.err = e_err; e.code = e_code;
      e.chk = chk; e.dat = e_dat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    rd_v[s] = 1'b0; wr_v[s] = 1'b0; by_v[s] = 1'b0;
    if (rst_at > 0) begin
      repeat (rst_at - 1) @(posedge clk);
      @(negedge clk);
      rst_v[s] = 1'b1;
      @(posedge clk); #1;
      rst_v[s] = 1'b0;
      n_vec++;
      if (busy_v[s] !== 1'b0 || done_v[s] !== 1'b0) begin
        n_miss++;
        $display("FAIL %s: got busy=%b done=%b after reset, want busy=0 done=0",
                 nm, busy_v[s], done_v[s]);
      end
      repeat (6) @(negedge clk);
    end else begin
      // Optional rd pulse across the next edge, while the request is busy.
      if (pulse) rd_v[s] = 1'b1;
      cyc = 0;
      while (cyc < 20) begin
        @(posedge clk); #1;
        rd_v[s] = 1'b0;
        cyc++;
        if (done_v[s] === 1'b1) break;
      end
      n_vec++;
      if (cyc != lat[s]) begin
        n_miss++;
        $display("FAIL %s latency: got %0d edges to done, want %0d", nm, cyc, lat[s]);
      end
    end
  endtask

  initial begin
    rst_v = 3'b111; rd_v = '0; wr_v = '0; by_v = '0;
    for (int k = 0; k < 3; k++) begin
      addr_v[k] = '0; din_v[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_v = 3'b000;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (dout_v[k] !== 16'd0 || busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 ||
          err_v[k] !== 1'b0 || code_v[k] !== 2'b00) begin
        n_miss++;
        $display("FAIL reset dut%0d: got data=%o busy=%b done=%b err=%b code=%b, want all 0",
                 k, dout_v[k], busy_v[k], done_v[k], err_v[k], code_v[k]);
      end
    end

    // WAIT_STATES=1 instance
    drive(0, "wr_1000",     0, 1, 0, 16'o1000,   16'o123456, 0, 2'b00, 0, 16'o0,      0, -1);
    drive(0, "rd_1000",     1, 0, 0, 16'o1000,   16'o0,      0, 2'b00, 1, 16'o123456, 0, -1);
    drive(0, "wr_2000",     0, 1, 0, 16'o2000,   16'o177777, 0, 2'b00, 0, 16'o0,      0, -1);
    drive(0, "bwr_2001",    0, 1, 1, 16'o2001,   16'o000000, 0, 2'b00, 0, 16'o0,      0, -1);
    drive(0, "rd_2000_a",   1, 0, 0, 16'o2000,   16'o0,      0, 2'b00, 1, 16'o000377, 0, -1);
    drive(0, "wwr_odd",     0, 1, 0, 16'o2001,   16'o055555, 1, 2'b01, 1, 16'o000377, 0, -1);
    drive(0, "rd_2000_b",   1, 0, 0, 16'o2000,   16'o0,      0, 2'b00, 1, 16'o000377, 0, -1);
    drive(0, "bwr_2001_hi", 0, 1, 1, 16'o2001,   16'o125000, 0, 2'b00, 0, 16'o0,      0, -1);
    drive(0, "bwr_2000_lo", 0, 1, 1, 16'o2000,   16'o000022, 0, 2'b00, 0, 16'o0,      0, -1);
    drive(0, "rd_2000_c",   1, 0, 0, 16'o2000,   16'o0,      0, 2'b00, 1, 16'o125022, 0, -1);
    drive(0, "wr_top",      0, 1, 0, 16'o77776,  16'o007070, 0, 2'b00, 0, 16'o0,      0, -1);
    drive(0, "rd_top",      1, 0, 0, 16'o77776,  16'o0,      0, 2'b00, 1, 16'o007070, 0, -1);
    drive(0, "rd_nxm",      1, 0, 0, 16'o100000, 16'o0,      1, 2'b10, 1, 16'o007070, 0, -1);
    drive(0, "wr_nxm",      0, 1, 0, 16'o100000, 16'o111111, 1, 2'b10, 1, 16'o007070, 0, -1);
    drive(0, "rdwr",        1, 1, 0, 16'o1000,   16'o0,      1, 2'b11, 1, 16'o007070, 0, -1);
    drive(0, "rdwr_prec",   1, 1, 0, 16'o100001, 16'o0,      1, 2'b11, 1, 16'o007070, 0, -1);
    drive(0, "odd_prec",    1, 0, 0, 16'o100001, 16'o0,      1, 2'b01, 1, 16'o007070, 0, -1);
    drive(0, "brd_odd",     1, 0, 1, 16'o1001,   16'o0,      0, 2'b00, 1, 16'o123456, 0, -1);
    drive(0, "rd_pulse",    1, 0, 0, 16'o2000,   16'o0,      0, 2'b00, 1, 16'o125022, 1, -1);
    drive(0, "rd_after",    1, 0, 0, 16'o77776,  16'o0,      0, 2'b00, 1, 16'o007070, 0, -1);

    // WAIT_STATES=3 instance: reset during WAIT aborts the write
    drive(1, "b_wr",        0, 1, 0, 16'o400,    16'o000111, 0, 2'b00, 0, 16'o0,      0, -1);
    drive(1, "b_rd",        1, 0, 0, 16'o400,    16'o0,      0, 2'b00, 1, 16'o000111, 0, -1);
    drive(1, "b_wr_abort",  0, 1, 0, 16'o400,    16'o000222, 0, 2'b00, 0, 16'o0,      0, 2);
    drive(1, "b_rd_old",    1, 0, 0, 16'o400,    16'o0,      0, 2'b00, 1, 16'o000111, 0, -1);

    // WAIT_STATES=0 instance: reset in ACK keeps the committed write
    drive(2, "c_wr",        0, 1, 0, 16'o600,    16'o000333, 0, 2'b00, 0, 16'o0,      0, -1);
    drive(2, "c_rd",        1, 0, 0, 16'o600,    16'o0,      0, 2'b00, 1, 16'o000333, 0, -1);
    drive(2, "c_wr_ackrst", 0, 1, 0, 16'o600,    16'o000444, 0, 2'b00, 0, 16'o0,      0, 1);
    drive(2, "c_rd_new",    1, 0, 0, 16'o600,    16'o0,      0, 2'b00, 1, 16'o000444, 0, -1);

    repeat (6) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL outstanding: got %0d completions still pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
